// File: rtl/excess3_serial_to_bcd_pkg.sv
// excess3_serial_to_bcd_pkg: Excess-3 constants and serial subtractor state encoding
package excess3_serial_to_bcd_pkg;
  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] RAW_MIN = 4'd3;
  localparam logic [3:0] RAW_MAX = 4'd12;
  typedef enum logic [2:0] {S0, S1_B0, S1_B1, S2_B0, S2_B1, S3_B0, S3_B1} e3_state_t;
endpackage

// File: rtl/e3_serial_sub3.sv
// e3_serial_sub3: LSB-first serial subtract-3 borrow FSM with registered bit output
module e3_serial_sub3
  import excess3_serial_to_bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic dat_in,
  input  logic dat_in_valid,
  output logic dat_out,
  output logic dat_out_valid,
  output logic bit_out,
  output logic borrow_next,
  output logic last_bit
);
  e3_state_t state, state_nxt;
  logic sub, borrow;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S0;
    else state <= state_nxt;
  always_comb begin
    sub = state == S0 || state == S1_B0 || state == S1_B1;
    borrow = state == S1_B1 || state == S2_B1 || state == S3_B1;
    bit_out = dat_in ^ sub ^ borrow;
    borrow_next = (~dat_in & (sub | borrow)) | (sub & borrow);
    last_bit = state == S3_B0 || state == S3_B1;
    state_nxt = !dat_in_valid ? state :
                last_bit ? S0 :
                state == S0 ? (borrow_next ? S1_B1 : S1_B0) :
                (state == S1_B0 || state == S1_B1) ? (borrow_next ? S2_B1 : S2_B0) :
                (borrow_next ? S3_B1 : S3_B0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dat_out <= 1'b0;
      dat_out_valid <= 1'b0;
    end else begin
      dat_out <= dat_in_valid ? bit_out : dat_out;
      dat_out_valid <= dat_in_valid;
    end
endmodule

// File: rtl/excess3_serial_to_bcd.sv
// excess3_serial_to_bcd: serial Excess-3 receiver assembling BCD digits and packed words
module excess3_serial_to_bcd
  import excess3_serial_to_bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  localparam int WORD_W = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dat_in,
  input  logic              dat_in_valid,
  output logic              dat_out,
  output logic              dat_out_valid,
  output logic [3:0]        digit_out,
  output logic              digit_valid,
  output logic              digit_err,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              word_err
);
  logic bit_out, borrow_next, last_bit, accept_last, derr, acc_err, acc_nxt, word_last;
  logic [3:0] raw_sr, bcd_sr, raw_full, bcd_full;
  logic [2:0] cnt;
  logic [WORD_W-1:0] word_buf, word_nxt;
  e3_serial_sub3 u_sub3 (
    .clk(clk),
    .rst_n(rst_n),
    .dat_in(dat_in),
    .dat_in_valid(dat_in_valid),
    .dat_out(dat_out),
    .dat_out_valid(dat_out_valid),
    .bit_out(bit_out),
    .borrow_next(borrow_next),
    .last_bit(last_bit)
  );
  always_comb begin
    raw_full = {dat_in, raw_sr[3:1]};
    bcd_full = {bit_out, bcd_sr[3:1]};
    accept_last = dat_in_valid & last_bit;
    // a final borrow means the raw code was below the Excess-3 offset
    derr = borrow_next | (raw_full > RAW_MAX);
    acc_nxt = (cnt == 3'd0) ? derr : (acc_err | derr);
    word_last = cnt == 3'(DIGITS - 1);
    word_nxt = word_buf;
    word_nxt[4*cnt +: 4] = bcd_full;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raw_sr <= '0;
      bcd_sr <= '0;
      cnt <= '0;
      acc_err <= 1'b0;
      word_buf <= '0;
      digit_out <= '0;
      digit_valid <= 1'b0;
      digit_err <= 1'b0;
      word_out <= '0;
      word_valid <= 1'b0;
      word_err <= 1'b0;
    end else begin
      digit_valid <= accept_last;
      word_valid <= accept_last & word_last;
      if (dat_in_valid) begin
        raw_sr <= raw_full;
        bcd_sr <= bcd_full;
      end
      if (accept_last) begin
        digit_out <= bcd_full;
        digit_err <= derr;
        word_buf <= word_nxt;
        acc_err <= acc_nxt;
        cnt <= word_last ? 3'd0 : cnt + 3'd1;
        if (word_last) begin
          word_out <= word_nxt;
          word_err <= acc_nxt;
        end
      end
    end
endmodule
